conv_ofmap_collector: RTL and testbench

CONV_OFMAP_COLLECTOR -- requirements
Module: conv_ofmap_collector

---
 rtl/conv_ofmap_collector.sv | 139 +++++++++++++
 tb/tb_conv_ofmap_collector.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_ofmap_collector.sv
// Packs four fp16 ofmap elements into a 2x2 tile and queues tiles in a small FIFO for downstream.
// Optional build macro COLLECTOR_RELU_EN clamps negative elements (sign bit set) to zero.
module conv_ofmap_collector #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] result,
    input  logic        dout_valid,
    input  logic        done,
    output logic [63:0] tile,
    output logic        tile_valid,
    input  logic        tile_ready,
    output logic [7:0]  tile_count,
    output logic        overflow,
    output logic        frag_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

    logic [1:0]    cnt_r;
    logic [15:0]   lane0_r, lane1_r, lane2_r;
    logic [63:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [AW:0]   occ_r;
    logic [63:0]   tile_r;
    logic          tile_valid_r;
    logic [7:0]    tile_count_r;
    logic          overflow_r, frag_err_r;

    logic [15:0]   elem_s;
    logic          complete_s, pop_s, full_s, push_s, drop_s, frag_s;
    logic [63:0]   new_tile_s, head_nxt_s;
    logic [AW:0]   occ_nxt_s;
    logic [AW-1:0] rd_nxt_s;

    function automatic logic [15:0] relu_f(input logic [15:0] x);
`ifdef COLLECTOR_RELU_EN
        relu_f = x[15] ? 16'h0000 : x;
`else
        relu_f = x;
`endif
    endfunction

    // Datapath decisions and the next FIFO head, so tile/tile_valid can be registered.
    always_comb begin
        elem_s     = relu_f(result);
        complete_s = dout_valid && (cnt_r == 2'd3);
        pop_s      = tile_valid_r && tile_ready;
        full_s     = (occ_r == FULL_C);
        push_s     = complete_s && (!full_s || pop_s);
        drop_s     = complete_s && full_s && !pop_s;
        frag_s     = done && (cnt_r != 2'd0) && !complete_s;
        new_tile_s = {elem_s, lane2_r, lane1_r, lane0_r};
        if (push_s && !pop_s) begin
            occ_nxt_s = occ_r + (AW+1)'(1);
        end else if (pop_s && !push_s) begin
            occ_nxt_s = occ_r - (AW+1)'(1);
        end else begin
            occ_nxt_s = occ_r;
        end
        rd_nxt_s = pop_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
        // A push lands on the next head slot only when the FIFO is (or becomes) empty.
        if (occ_nxt_s == (AW+1)'(0)) begin
            head_nxt_s = tile_r;
        end else if (push_s && (wr_ptr_r == rd_nxt_s)) begin
            head_nxt_s = new_tile_s;
        end else begin
            head_nxt_s = mem_r[rd_nxt_s];
        end
    end

    // Element counter and lane capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= 2'd0;
            lane0_r <= 16'h0000;
            lane1_r <= 16'h0000;
            lane2_r <= 16'h0000;
        end else if (frag_s) begin
            cnt_r <= 2'd0;
        end else if (dout_valid) begin
            case (cnt_r)
                2'd0:    lane0_r <= elem_s;
                2'd1:    lane1_r <= elem_s;
                2'd2:    lane2_r <= elem_s;
                default: lane2_r <= lane2_r;
            endcase
            cnt_r <= cnt_r + 2'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= new_tile_s;
        end
    end

    // FIFO pointers, occupancy and registered head presentation.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            occ_r        <= '0;
            tile_r       <= 64'h0;
            tile_valid_r <= 1'b0;
        end else begin
            wr_ptr_r     <= push_s ? (wr_ptr_r + AW'(1)) : wr_ptr_r;
            rd_ptr_r     <= rd_nxt_s;
            occ_r        <= occ_nxt_s;
            tile_r       <= head_nxt_s;
            tile_valid_r <= (occ_nxt_s != (AW+1)'(0));
        end
    end

    // Tile counter and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            tile_count_r <= 8'd0;
            overflow_r   <= 1'b0;
            frag_err_r   <= 1'b0;
        end else begin
            tile_count_r <= push_s ? (tile_count_r + 8'd1) : tile_count_r;
            overflow_r   <= overflow_r || drop_s;
            frag_err_r   <= frag_err_r || frag_s;
        end
    end

    assign tile       = tile_r;
    assign tile_valid = tile_valid_r;
    assign tile_count = tile_count_r;
    assign overflow   = overflow_r;
    assign frag_err   = frag_err_r;

endmodule

// File: tb/tb_conv_ofmap_collector.sv
// Directed and randomized bench for conv_ofmap_collector against a queue-based reference model.
module tb_conv_ofmap_collector;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst, dout_valid, done, tile_ready;
    logic [15:0] result;
    logic [63:0] tile;
    logic        tile_valid, overflow, frag_err;
    logic [7:0]  tile_count;

    int checks = 0;
    int errors = 0;

    logic [63:0] m_q [$];
    logic [15:0] m_parts [$];
    logic [7:0]  m_count;
    logic        m_ovf, m_frag, m_zero;

    always #5 clk = ~clk;

    conv_ofmap_collector #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .result(result), .dout_valid(dout_valid), .done(done),
        .tile(tile), .tile_valid(tile_valid), .tile_ready(tile_ready),
        .tile_count(tile_count), .overflow(overflow), .frag_err(frag_err)
    );

    function automatic logic [15:0] relu(input logic [15:0] x);
`ifdef COLLECTOR_RELU_EN
        return x[15] ? 16'h0000 : x;
`else
        return x;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour for one clock edge, using the inputs presented at that edge.
    task automatic model_edge();
        logic pop, full;
        logic [63:0] t;
        pop  = (m_q.size() != 0) && tile_ready;
        full = (m_q.size() == DEPTH);
        if (rst) begin
            m_q.delete();
            m_parts.delete();
            m_count = 8'd0;
            m_ovf = 1'b0;
            m_frag = 1'b0;
            m_zero = 1'b1;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (done && m_parts.size() != 0 && !(dout_valid && m_parts.size() == 3)) begin
                m_parts.delete();
                m_frag = 1'b1;
            end else if (dout_valid) begin
                m_parts.push_back(relu(result));
                if (m_parts.size() == 4) begin
                    t = {m_parts[3], m_parts[2], m_parts[1], m_parts[0]};
                    m_parts.delete();
                    if (!full || pop) begin
                        m_q.push_back(t);
                        m_count = m_count + 8'd1;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
        end
        if (m_q.size() != 0) m_zero = 1'b0;
    endtask

    task automatic step(input logic r, input logic dv, input logic [15:0] res,
                        input logic dn, input logic rdy);
        rst = r; dout_valid = dv; result = res; done = dn; tile_ready = rdy;
        @(posedge clk);
        model_edge();
        #1;
        chk("tile_valid", {63'd0, tile_valid}, {63'd0, m_q.size() != 0});
        if (m_q.size() != 0) chk("tile", tile, m_q[0]);
        if (m_zero) chk("tile_reset_zero", tile, 64'h0);
        chk("tile_count", {56'd0, tile_count}, {56'd0, m_count});
        chk("overflow", {63'd0, overflow}, {63'd0, m_ovf});
        chk("frag_err", {63'd0, frag_err}, {63'd0, m_frag});
    endtask

    task automatic send4(input logic [63:0] t, input logic rdy);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, t[16*k +: 16], 1'b0, rdy);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [63:0] exp_t;
        m_q.delete(); m_parts.delete();
        m_count = 8'd0; m_ovf = 1'b0; m_frag = 1'b0; m_zero = 1'b1;
        rst = 1'b1; dout_valid = 1'b0; done = 1'b0; tile_ready = 1'b0; result = 16'h0;

        // Reset state
        do_reset();
        do_reset();
        chk("reset_valid", {63'd0, tile_valid}, 64'd0);
        chk("reset_tile", tile, 64'h0);

        // Basic tile with 1-cycle latency
        send4(64'h4400_4200_4000_3C00, 1'b1);
        chk("basic_tile", tile, 64'h4400_4200_4000_3C00);
        chk("basic_valid", {63'd0, tile_valid}, 64'd1);
        chk("basic_count", {56'd0, tile_count}, 64'd1);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        chk("basic_one_cycle", {63'd0, tile_valid}, 64'd0);

        // Backpressure and overflow
        do_reset();
        send4(64'h1111_2222_3333_4444, 1'b0);
        send4(64'h5555_6666_7777_0123, 1'b0);
        send4(64'h0AAA_0BBB_0CCC_0DDD, 1'b0);
        chk("ovf_flag", {63'd0, overflow}, 64'd1);
        chk("ovf_count", {56'd0, tile_count}, 64'd2);
        chk("ovf_head1", tile, 64'h1111_2222_3333_4444);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        chk("ovf_head2", tile, 64'h5555_6666_7777_0123);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        chk("ovf_drained", {63'd0, tile_valid}, 64'd0);

        // Full FIFO with simultaneous pop
        do_reset();
        send4(64'h1000_1001_1002_1003, 1'b0);
        send4(64'h2000_2001_2002_2003, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 16'h3000 + 16'(k), 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h3003, 1'b0, 1'b1);
        chk("fullpop_ovf", {63'd0, overflow}, 64'd0);
        chk("fullpop_count", {56'd0, tile_count}, 64'd3);
        chk("fullpop_head", tile, 64'h2000_2001_2002_2003);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        chk("fullpop_third", tile, 64'h3003_3002_3001_3000);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);

        // Fragment discarded on done
        do_reset();
        step(1'b0, 1'b1, 16'h7001, 1'b0, 1'b1);
        step(1'b0, 1'b1, 16'h7002, 1'b0, 1'b1);
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        chk("frag_flag", {63'd0, frag_err}, 64'd1);
        chk("frag_nopush", {56'd0, tile_count}, 64'd0);
        send4(64'h0004_0003_0002_0001, 1'b1);
        chk("frag_clean_tile", tile, 64'h0004_0003_0002_0001);

        // done together with the completing element
        do_reset();
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 16'h0100 + 16'(k), 1'b0, 1'b1);
        step(1'b0, 1'b1, 16'h0103, 1'b1, 1'b1);
        chk("done_complete_frag", {63'd0, frag_err}, 64'd0);
        chk("done_complete_tile", tile, 64'h0103_0102_0101_0100);
        // done with an empty counter does nothing
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        chk("done_idle_frag", {63'd0, frag_err}, 64'd0);

        // ReLU on a negative lane
        do_reset();
        send4(64'h4200_4000_BC00_3C00, 1'b1);
`ifdef COLLECTOR_RELU_EN
        exp_t = 64'h4200_4000_0000_3C00;
`else
        exp_t = 64'h4200_4000_BC00_3C00;
`endif
        chk("relu_tile", tile, exp_t);

        // Reset in the middle of a tile
        do_reset();
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 16'h0E00 + 16'(k), 1'b0, 1'b1);
        step(1'b1, 1'b1, 16'h0EEE, 1'b0, 1'b1);
        send4(64'h0D04_0D03_0D02_0D01, 1'b1);
        chk("midrst_tile", tile, 64'h0D04_0D03_0D02_0D01);
        chk("midrst_count", {56'd0, tile_count}, 64'd1);
        chk("midrst_flags", {62'd0, overflow, frag_err}, 64'd0);

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            logic r, dv, dn, rdy;
            r   = ($urandom_range(0, 499) == 0);
            dv  = ($urandom_range(0, 9) < 6);
            dn  = !dv && ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 1) == 1);
            step(r, dv, 16'($urandom), dn, rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
